// File: rtl/conv_stream_if.sv
// Pixel-in / result-out handshake bundle for the streaming 3x3 convolution engine.
interface conv_stream_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = PIX_W + 3
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    // Pixel source / result sink side
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Convolution engine side
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv_stream_engine.sv
// Streaming 3x3 convolution over a raster-order frame: two line buffers feed a
// sliding window; Gaussian, Sobel-X, Sobel-Y or centre passthrough per frame.
// Only interior window centres produce results (no padding).
module conv_stream_engine #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int OUT_W = PIX_W + 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         frame_done,
    conv_stream_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    // Gaussian sum peaks just below 2^(PIX_W+4); one extra bit for sign
    localparam int S_W   = PIX_W + 5;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t           state_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic [1:0]       mode_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic             frame_done_reg;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [PIX_W-1:0] lb0_mem [IMG_W];
    logic [PIX_W-1:0] lb1_mem [IMG_W];
    logic [PIX_W-1:0] lb0_rd_reg;
    logic [PIX_W-1:0] lb1_rd_reg;

    // Two stored window columns; the third (newest) column is live from the
    // buffer read registers and the incoming pixel, so the registered output
    // sees a full 3x3 window in the cycle the completing pixel arrives.
    logic [PIX_W-1:0] win_reg [3][2];
    logic [PIX_W-1:0] new_col [3];
    logic [PIX_W-1:0] nw      [3][3];
    logic signed [S_W-1:0] p  [3][3];

    logic             accepting;
    logic             in_ready_int;
    logic             xfer;
    logic             out_fire;
    logic             start_accept;
    logic             col_last;
    logic             row_last;
    logic             win_valid;
    logic [COL_W-1:0] col_next;
    logic [COL_W-1:0] rd_addr;
    logic signed [S_W-1:0] gauss_sum;
    logic signed [S_W-1:0] sobel_x;
    logic signed [S_W-1:0] sobel_y;
    logic signed [S_W-1:0] result_acc;

    assign accepting    = (state_reg == FILL) || (state_reg == RUN);
    assign in_ready_int = accepting && (!out_valid_reg || bus.out_ready);
    assign xfer         = bus.in_valid && in_ready_int;
    assign out_fire     = out_valid_reg && bus.out_ready;
    assign start_accept = (state_reg == IDLE) && start;
    assign col_last     = (col_reg == COL_W'(IMG_W - 1));
    assign row_last     = (row_reg == ROW_W'(IMG_H - 1));
    assign col_next     = col_last ? '0 : col_reg + 1'b1;
    assign win_valid    = (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));
    // Prefetch the column the next pixel will land on
    assign rd_addr      = start_accept ? '0 : col_next;

    assign new_col[0] = lb1_rd_reg;
    assign new_col[1] = lb0_rd_reg;
    assign new_col[2] = bus.in_pixel;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign nw[gi][0] = win_reg[gi][0];
            assign nw[gi][1] = win_reg[gi][1];
            assign nw[gi][2] = new_col[gi];
            for (gj = 0; gj < 3; gj++) begin : g_col
                assign p[gi][gj] = $signed({{(S_W - PIX_W){1'b0}}, nw[gi][gj]});
            end
        end
    endgenerate

    // Kernel arithmetic on the window that includes the pixel being accepted
    always_comb begin
        gauss_sum = p[0][0] + (p[0][1] <<< 1) + p[0][2]
                  + (p[1][0] <<< 1) + (p[1][1] <<< 2) + (p[1][2] <<< 1)
                  + p[2][0] + (p[2][1] <<< 1) + p[2][2];
        sobel_x   = (p[0][2] - p[0][0]) + ((p[1][2] - p[1][0]) <<< 1) + (p[2][2] - p[2][0]);
        sobel_y   = (p[2][0] - p[0][0]) + ((p[2][1] - p[0][1]) <<< 1) + (p[2][2] - p[0][2]);
        result_acc = '0;
        case (mode_reg)
            2'd0:    result_acc = (gauss_sum + S_W'(8)) >>> 4;
            2'd1:    result_acc = sobel_x;
            2'd2:    result_acc = sobel_y;
            default: result_acc = p[1][1];
        endcase
    end

    // Line buffer write plus registered prefetch read (distinct addresses)
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb0_mem[col_reg] <= bus.in_pixel;
            lb1_mem[col_reg] <= lb0_rd_reg;
        end
        if (start_accept || xfer) begin
            lb0_rd_reg <= lb0_mem[rd_addr];
            lb1_rd_reg <= lb1_mem[rd_addr];
        end
    end

    // Slide the window one column on every accepted pixel
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < 3; i++) begin
                win_reg[i][0] <= nw[i][1];
                win_reg[i][1] <= nw[i][2];
            end
        end
    end

    // Frame sequencing, raster counters and the single output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            mode_reg       <= 2'd0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (xfer && win_valid) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= OUT_W'(result_acc);
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        state_reg <= FILL;
                    end
                end
                FILL, RUN: begin
                    if (xfer) begin
                        col_reg <= col_next;
                        if (col_last) begin
                            row_reg <= row_last ? '0 : row_reg + 1'b1;
                        end
                        if (col_last && row_last) begin
                            state_reg <= DRAIN;
                        end else if (state_reg == FILL && row_reg == ROW_W'(2)
                                     && col_reg == COL_W'(2)) begin
                            state_reg <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        frame_done_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign frame_done    = frame_done_reg;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed frames on a 5x4 image; expected results come from a tap-table
// model, queued when the completing pixel is accepted and popped on output.
module tb_conv_stream_engine;
    localparam int PIX_W = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int OUT_W = 11;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       busy;
    logic       frame_done;

    conv_stream_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

    conv_stream_engine #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int img [NPIX];
    logic [OUT_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input int m, input int r, input int c);
        int gk [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int sx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int sy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        int acc = 0;
        int k;
        if (m == 3) return OUT_W'(img[r * IMG_W + c]);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                k = i * 3 + j;
                acc += ((m == 0) ? gk[k] : (m == 1) ? sx[k] : sy[k])
                       * img[(r - 1 + i) * IMG_W + (c - 1 + j)];
            end
        end
        if (m == 0) acc = (acc + 8) / 16;
        return OUT_W'(acc);
    endfunction

    task automatic fill_image(input int pat);
        int r, c;
        for (int idx = 0; idx < NPIX; idx++) begin
            r = idx / IMG_W;
            c = idx % IMG_W;
            case (pat)
                0: img[idx] = 100;
                1: img[idx] = c * 10;
                2: img[idx] = r * 20;
                3: img[idx] = 255;
                4: img[idx] = r * 5 + c;
                default: img[idx] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic run_frame(input int m, input bit stall, input bit rnd,
                             input int abort_after, input int midstart_at, input string name);
        int idx = 0, got = 0, dones = 0, cyc = 0, after = 0, r, c;
        bit held_v = 1'b0;
        bit ms_done = 1'b0;
        logic [OUT_W-1:0] held = '0;
        logic [OUT_W-1:0] e;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'(m);
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        while (cyc < 400) begin
            bus.out_ready = stall ? (cyc % 2 == 0) : 1'b1;
            bus.in_valid  = (idx < NPIX) && (!rnd || $urandom_range(0, 1) == 1);
            bus.in_pixel  = (idx < NPIX) ? 8'(img[idx]) : 8'd0;
            if (!ms_done && idx == midstart_at) begin
                start = 1'b1;
                mode  = 2'd1;
                ms_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (frame_done) begin
                dones++;
                check({name, " results_before_done"}, 32'(got), 32'(NRES));
                check({name, " queue_empty_at_done"}, 32'(exp_q.size()), 32'd0);
            end
            if (held_v) begin
                check({name, " stall_valid_hold"}, 32'(bus.out_valid), 32'd1);
                check({name, " stall_data_hold"}, 32'(bus.out_data), 32'(held));
            end
            held_v = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check({name, " in_ready_blocked"}, 32'(bus.in_ready), 32'd0);
                held   = bus.out_data;
                held_v = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, " unexpected_output"}, 32'(bus.out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    $display("%s result %0d: out=%0d exp=%0d", name, got,
                             $signed(bus.out_data), $signed(e));
                    check({name, " out_data"}, 32'(bus.out_data), 32'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                r = idx / IMG_W;
                c = idx % IMG_W;
                if (r >= 2 && c >= 2) exp_q.push_back(model(m, r - 1, c - 1));
                idx++;
                if (idx == abort_after) break;
            end
            if (dones > 0) after++;
            if (after == 4) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (abort_after < 0) begin
            check({name, " frame_done_count"}, 32'(dones), 32'd1);
            check({name, " result_count"}, 32'(got), 32'(NRES));
            check({name, " idle_busy"}, 32'(busy), 32'd0);
            bus.in_valid = 1'b1;
            #1;
            check({name, " idle_in_ready"}, 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", 32'(bus.out_data), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        fill_image(0); run_frame(0, 1'b0, 1'b0, -1, -1, "gauss_100");
        fill_image(1); run_frame(1, 1'b0, 1'b0, -1, -1, "sobx_col");
        run_frame(2, 1'b0, 1'b0, -1, -1, "soby_col");
        fill_image(2); run_frame(2, 1'b0, 1'b0, -1, -1, "soby_row");
        fill_image(3); run_frame(0, 1'b0, 1'b0, -1, -1, "gauss_255");
        fill_image(5); run_frame(1, 1'b1, 1'b1, -1, -1, "sobx_stall");
        fill_image(5); run_frame(0, 1'b1, 1'b1, -1, -1, "gauss_stall");

        // Abort mid-frame: asynchronous reset takes effect before the next edge
        fill_image(4); run_frame(0, 1'b0, 1'b0, 9, -1, "aborted");
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd0);
        check("abort frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(3, 1'b0, 1'b0, -1, -1, "pass_after_abort");

        fill_image(4); run_frame(0, 1'b0, 1'b0, -1, 10, "midstart_ignored");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_stream_engine.md
CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 Parameter PIX_W, default 8: input pixel width, unsigned.
REQ-002 Parameter IMG_W, default 512: pixels per row, minimum 3.
REQ-003 Parameter IMG_H, default 512: rows per frame, minimum 3.
REQ-004 Parameter OUT_W, default PIX_W+3: output width, two's complement.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle frame start request.
REQ-008 mode  input  2  kernel select: 0 Gaussian, 1 Sobel-X, 2 Sobel-Y, 3 passthrough (centre tap).
REQ-009 in_valid / in_ready  input / output  1 / 1  raster-order pixel handshake.
REQ-010 in_pixel  input  PIX_W  pixel value.
REQ-011 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 out_data  output  OUT_W  convolution result.
REQ-013 busy  output  1  high in FILL, RUN, DRAIN.
REQ-014 frame_done  output  1  one-cycle pulse after last result transferred.

Function
REQ-015 FSM states IDLE, FILL, RUN, DRAIN; start in IDLE latches mode and enters FILL; start or mode change outside IDLE ignored.
REQ-016 Transfer occurs on in_valid & in_ready; column counter wraps IMG_W-1 -> 0 and increments row counter; both clear on start.
REQ-017 Two line buffers of IMG_W x PIX_W plus a 3x3 register window; a row's pixel available to the window IMG_W and 2*IMG_W transfers later.
REQ-018 FILL until transfer at row 2, column 2 is accepted, then RUN.
REQ-019 A result is produced only for window centres at rows 1..IMG_H-2, columns 1..IMG_W-2: exactly (IMG_W-2)*(IMG_H-2) results per frame, no padding, no results across row wrap.
REQ-020 Latency: out_valid asserts the cycle after the transfer completing a valid window (1-cycle registered output).
REQ-021 Gaussian: taps 1 2 1 / 2 4 2 / 1 2 1, result (sum+8)>>4, zero-extended to OUT_W; max input gives max PIX_W value.
REQ-022 Sobel-X: taps -1 0 1 / -2 0 2 / -1 0 1 (right column positive); Sobel-Y: top row -1 -2 -1, bottom row +1 +2 +1; signed result, no saturation, range +-4*(2^PIX_W-1).
REQ-023 Passthrough: centre pixel zero-extended.
REQ-024 Single output register: in_ready = busy-in-FILL/RUN & (!out_valid | out_ready); out_data and out_valid hold stable while out_valid & !out_ready.
REQ-025 After transfer at row IMG_H-1, column IMG_W-1, enter DRAIN, in_ready low.
REQ-026 DRAIN: on final output transfer, frame_done pulses one cycle, state IDLE; start in that same cycle is ignored.
REQ-027 in_valid ignored in IDLE and DRAIN (in_ready low).

Reset
REQ-028 On reset: state IDLE, counters 0, out_valid 0, out_data 0, in_ready 0, busy 0, frame_done 0, latched mode 0.
REQ-029 Reset mid-frame aborts frame with no frame_done; line buffer contents need not be cleared; next frame after start is fully correct.

Verification (IMG_W=5, IMG_H=4, PIX_W=8)
REQ-030 Gaussian, all pixels 100, out_ready=1 -> 6 results all 100, frame_done once after 6th.
REQ-031 Sobel-X, pixel=col*10 -> 6 results all +80; Sobel-Y same image -> all 0.
REQ-032 Sobel-Y, pixel=row*20 -> all +160; Gaussian all 255 -> all 255.
REQ-033 out_ready toggled 1-0 each cycle, in_valid random -> identical 6-value sequence, out_data stable while stalled, no input accepted while output full and stalled.
REQ-034 Reset asserted after 9 pixels, then start with mode 3 and pixel=row*5+col -> results 6,7,8,11,12,13, no frame_done from aborted frame.
REQ-035 start with mode 1 pulsed mid-frame of mode-0 frame -> ignored, mode-0 results, single frame_done.
